// File: rtl/serial_in.sv
// serial_in: 8N1 UART receiver. The RX line is oversampled at 16x baud by a
// DDS tick generator, each bit is decided by a 2-of-3 majority around its
// mid-point, and accepted bytes are pushed to a downstream FIFO with a
// single-cycle write request. Frame errors and overruns are one-cycle pulses.
`timescale 1ns/1ps
module serial_in #(
    parameter int unsigned CLOCK     = 56842105,
    parameter int unsigned BAUD_RATE = 115200,
    parameter logic [31:0] DDS_M_RX  =
        32'(((64'd1 << 32) * 64'd16 * 64'(BAUD_RATE)) / 64'(CLOCK))
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_serial_rx,
    input  logic       i_fifo_full,
    output logic [7:0] o_data,
    output logic       o_fifo_write_req,
    output logic       o_frame_error,
    output logic       o_overrun,
    output logic       o_rx_active
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    // 2-of-3 vote over the samples taken at cnt 7, 8 and 9
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [32:0] acc_sum;
    logic        tick;

    logic        rx_meta_q;
    logic        rx_s_q;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_nx;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        samp7_q;
    logic        samp8_q;
    logic        maj;

    logic [7:0]  data_q;
    logic        wr_q;
    logic        ferr_q;
    logic        ovr_q;

    // The carry out of the phase accumulator is the 16x baud tick
    assign acc_sum = {1'b0, acc_q} + {1'b0, DDS_M_RX};
    assign acc_d   = acc_sum[31:0];
    assign tick    = acc_sum[32];

    // Tick position within the current bit once this tick is counted
    assign cnt_nx  = cnt_q + 4'd1;
    assign maj     = maj3(samp7_q, samp8_q, rx_s_q);

    // Phase accumulator for the oversampling tick
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_serial_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive state machine; advances only on ticks, pulses last one clock
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            samp7_q <= 1'b1;
            samp8_q <= 1'b1;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (tick) begin
                // Bit-timed states share the tick counter and sample capture
                if (state_q == START || state_q == DATA || state_q == STOP) begin
                    cnt_q <= cnt_nx;
                    if (cnt_nx == 4'd7) samp7_q <= rx_s_q;
                    if (cnt_nx == 4'd8) samp8_q <= rx_s_q;
                end
                case (state_q)
                    IDLE: begin
                        if (!rx_s_q) begin
                            cnt_q   <= '0;
                            state_q <= START;
                        end
                    end
                    START: begin
                        if (cnt_nx == 4'd9 && maj) begin
                            // Start bit did not hold low through mid-bit: glitch
                            state_q <= IDLE;
                        end else if (cnt_nx == 4'd15) begin
                            idx_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (cnt_nx == 4'd9) begin
                            shift_q <= {maj, shift_q[7:1]};
                        end
                        if (cnt_nx == 4'd15) begin
                            if (idx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        // Decide at mid stop bit so a following start edge
                        // half a bit later is still caught
                        if (cnt_nx == 4'd9) begin
                            if (maj) begin
                                if (!i_fifo_full) begin
                                    data_q <= shift_q;
                                    wr_q   <= 1'b1;
                                end else begin
                                    ovr_q  <= 1'b1;
                                end
                                state_q <= IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= BREAK;
                            end
                        end
                    end
                    BREAK: begin
                        // Hold off new frames until the line returns high
                        if (rx_s_q) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_data           = data_q;
    assign o_fifo_write_req = wr_q;
    assign o_frame_error    = ferr_q;
    assign o_overrun        = ovr_q;
    assign o_rx_active      = (state_q != IDLE);

endmodule
